// File: rtl/conv_window_gen_pkg.sv
// Shared constants and helpers for the streaming convolution window generator.
package conv_window_gen_pkg;

    localparam int unsigned DEF_PIX_W = 9;
    localparam int unsigned DEF_K_H   = 3;
    localparam int unsigned DEF_K_W   = 3;
    localparam int unsigned DEF_IMG_W = 28;
    localparam int unsigned DEF_IMG_H = 28;
    localparam int unsigned DEF_WIN_COUNT = (DEF_IMG_H - DEF_K_H + 1) * (DEF_IMG_W - DEF_K_W + 1);

    // Flat bit offset of window element (r,c); r=0 is the oldest row, c=0 the leftmost column.
    function automatic int unsigned win_offset(input int unsigned r, input int unsigned c,
                                               input int unsigned k_w, input int unsigned pix_w);
        return (r * k_w + c) * pix_w;
    endfunction

    // Number of valid (no-padding) windows in one frame.
    function automatic int unsigned win_count(input int unsigned img_h, input int unsigned k_h,
                                              input int unsigned img_w, input int unsigned k_w);
        return (img_h - k_h + 1) * (img_w - k_w + 1);
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One image row of pixel storage; read-before-write at the same index per transfer.
module conv_line_buffer
    import conv_window_gen_pkg::*;
#(
    parameter int unsigned IMG_W = DEF_IMG_W,
    parameter int unsigned PIX_W = DEF_PIX_W,
    localparam int unsigned IDX_W = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] idx,
    input  logic [PIX_W-1:0] wr_data,
    output logic [PIX_W-1:0] rd_data_c
);

    logic [PIX_W-1:0] mem [IMG_W];

    // Storage is deliberately not reset; stale rows are never emitted by the top.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[idx] <= wr_data;
        end
    end

    assign rd_data_c = mem[idx];

endmodule

// File: rtl/conv_window_gen.sv
// Raster-order K_H x K_W window generator with a single registered output stage.
// Optional out_last port (final window of a frame) enabled by CONV_WIN_LAST_EN.
module conv_window_gen
    import conv_window_gen_pkg::*;
#(
    parameter int unsigned K_H   = DEF_K_H,
    parameter int unsigned K_W   = DEF_K_W,
    parameter int unsigned IMG_W = DEF_IMG_W,
    parameter int unsigned IMG_H = DEF_IMG_H,
    parameter int unsigned PIX_W = DEF_PIX_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PIX_W-1:0]         in_pix,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [K_H*K_W*PIX_W-1:0] out_win,
    output logic                     frame_done
`ifdef CONV_WIN_LAST_EN
    ,
    output logic                     out_last
`endif
);

    localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned WIN_W = K_H * K_W * PIX_W;

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [WIN_W-1:0] win;
    logic [WIN_W-1:0] win_nxt_c;
    logic [PIX_W-1:0] lb_rd_c [K_H-1];
    logic             in_xfer_c;
    logic             col_last_c;
    logic             row_last_c;
    logic             frame_last_c;
    logic             qual_c;

    assign in_ready     = !out_valid || out_ready;
    assign in_xfer_c    = in_valid && in_ready;
    assign col_last_c   = (col == COL_W'(IMG_W - 1));
    assign row_last_c   = (row == ROW_W'(IMG_H - 1));
    assign frame_last_c = col_last_c && row_last_c;
    assign qual_c       = (row >= ROW_W'(K_H - 1)) && (col >= COL_W'(K_W - 1));

    // Line buffer chain: buffer 0 holds the oldest row, the last one the previous row.
    for (genvar g = 0; g < K_H - 1; g++) begin : g_lb
        logic [PIX_W-1:0] wr_data_c;
        if (g == K_H - 2) begin : g_last
            assign wr_data_c = in_pix;
        end else begin : g_mid
            assign wr_data_c = lb_rd_c[g+1];
        end
        conv_line_buffer #(
            .IMG_W (IMG_W),
            .PIX_W (PIX_W)
        ) u_lb (
            .clk       (clk),
            .wr_en     (in_xfer_c),
            .idx       (col),
            .wr_data   (wr_data_c),
            .rd_data_c (lb_rd_c[g])
        );
    end

    // Shift every window row left and load the new right-hand column.
    always_comb begin
        win_nxt_c = win;
        for (int unsigned r = 0; r < K_H; r++) begin
            for (int unsigned c = 0; c < K_W - 1; c++) begin
                win_nxt_c[win_offset(r, c, K_W, PIX_W) +: PIX_W] =
                    win[win_offset(r, c + 1, K_W, PIX_W) +: PIX_W];
            end
        end
        for (int unsigned r = 0; r < K_H - 1; r++) begin
            win_nxt_c[win_offset(r, K_W - 1, K_W, PIX_W) +: PIX_W] = lb_rd_c[r];
        end
        win_nxt_c[win_offset(K_H - 1, K_W - 1, K_W, PIX_W) +: PIX_W] = in_pix;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row        <= '0;
            col        <= '0;
            win        <= '0;
            out_valid  <= 1'b0;
            out_win    <= '0;
            frame_done <= 1'b0;
`ifdef CONV_WIN_LAST_EN
            out_last   <= 1'b0;
`endif
        end else begin
            frame_done <= in_xfer_c && frame_last_c;
            if (in_xfer_c) begin
                win <= win_nxt_c;
                if (col_last_c) begin
                    col <= '0;
                    row <= row_last_c ? '0 : row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end
            // Output stage loads only on a qualifying pixel; in_ready guarantees it is free.
            if (in_xfer_c && qual_c) begin
                out_valid <= 1'b1;
                out_win   <= win_nxt_c;
`ifdef CONV_WIN_LAST_EN
                out_last  <= frame_last_c;
`endif
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
